dma_io_device: RTL and testbench

DMA_IO_DEVICE -- requirements
Module: dma_io_device

---
 rtl/dma_io_device.sv | 160 ++++++++++++++++
 tb/tb_dma_io_device.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_io_device.sv
// Device end of an 8237-style DREQ/DACK channel with a 4-deep byte FIFO per direction.
// Optional terminal count (EOP_OUT_N, blockLen) is built only when DMA_DEV_TERMINAL_COUNT_EN is defined.
module dma_io_device (
  input  logic       CLK,
  input  logic       RESET,
  output logic       DREQ,
  input  logic       DACK,
  input  logic       IOR_N,
  input  logic       IOW_N,
  input  logic       EOP_N,
  input  logic [7:0] DB,
  output logic [7:0] DB_OUT,
  output logic       DB_OE,
  output logic       EOP_OUT_N,
  input  logic       enable,
  input  logic       dir,
  input  logic       demandMode,
  input  logic       txPush,
  input  logic [7:0] txData,
  output logic       txFull,
  input  logic       rxPop,
  output logic [7:0] rxData,
  output logic       rxEmpty,
  input  logic [7:0] blockLen,
  output logic [1:0] dbg_state
);

  // Handshake: DREQ is held while the device wants a byte; every byte moves on a
  // qualified strobe falling edge (high last cycle, low now, DACK=1) while in XFER.
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, XFER = 2'd2, GAP = 2'd3} state_t;

  state_t     state, state_next;
  logic       ior_q, iow_q, eop_block;

  logic [7:0] tx_mem [4];
  logic [1:0] tx_wr, tx_rd;
  logic [2:0] tx_cnt, tx_cnt_next;
  logic [7:0] rx_mem [4];
  logic [1:0] rx_wr, rx_rd;
  logic [2:0] rx_cnt, rx_cnt_next;

  logic tx_empty, rx_full;
  logic strobe_ok, tx_pop, tx_push, rx_push, rx_pop, byte_done;
  logic ready_now, ready_next, eop_in, tc_hit;

  assign tx_empty = (tx_cnt == 3'd0);
  assign txFull   = (tx_cnt == 3'd4);
  assign rx_full  = (rx_cnt == 3'd4);
  assign rxEmpty  = (rx_cnt == 3'd0);
  assign rxData   = rx_mem[rx_rd];

  // eop_block keeps an aborted transfer from restarting until the controller releases DACK.
  assign strobe_ok = (state == XFER) && DACK && !eop_block;
  assign tx_pop    = strobe_ok && dir && ior_q && !IOR_N && !tx_empty;
  assign rx_push   = strobe_ok && !dir && iow_q && !IOW_N && !rx_full;
  assign tx_push   = txPush && (!txFull || tx_pop);
  assign rx_pop    = rxPop && !rxEmpty;
  assign byte_done = tx_pop || rx_push;

  assign tx_cnt_next = tx_cnt + {2'b00, tx_push} - {2'b00, tx_pop};
  assign rx_cnt_next = rx_cnt + {2'b00, rx_push} - {2'b00, rx_pop};
  assign ready_now   = dir ? !tx_empty : !rx_full;
  assign ready_next  = dir ? (tx_cnt_next != 3'd0) : (rx_cnt_next != 3'd4);
  assign eop_in      = !EOP_N && ((state == REQ) || (state == XFER));

  assign DB_OE     = !RESET && DACK && !IOR_N && dir;
  assign DB_OUT    = DB_OE ? tx_mem[tx_rd] : 8'h00;
  assign dbg_state = state;

`ifdef DMA_DEV_TERMINAL_COUNT_EN
  logic [7:0] byte_cnt;
  logic       eop_out_q;

  // blockLen of 0 wraps naturally to a 256-byte block through the 8-bit compare.
  assign tc_hit    = byte_done && ((byte_cnt + 8'd1) == blockLen);
  assign EOP_OUT_N = eop_out_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      byte_cnt  <= 8'd0;
      eop_out_q <= 1'b1;
    end else begin
      eop_out_q <= !tc_hit;
      if (tc_hit || eop_in)
        byte_cnt <= 8'd0;
      else if (byte_done)
        byte_cnt <= byte_cnt + 8'd1;
    end
  end
`else
  logic unused_blocklen;
  assign unused_blocklen = ^blockLen;
  assign tc_hit          = 1'b0;
  assign EOP_OUT_N       = 1'b1;
`endif

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (enable && ready_now && !eop_block) state_next = REQ;
      REQ: begin
        if (eop_in)    state_next = IDLE;
        else if (DACK) state_next = XFER;
      end
      XFER: begin
        if (eop_in || tc_hit) state_next = IDLE;
        else if (demandMode) begin
          if (!ready_next) state_next = IDLE;
        end else if (byte_done) state_next = GAP;
      end
      GAP: begin
        // GAP is the single low DREQ cycle; re-request straight away if still wanted.
        if (enable && ready_now && !eop_block) state_next = REQ;
        else                                   state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= IDLE;
      DREQ      <= 1'b0;
      ior_q     <= 1'b1;
      iow_q     <= 1'b1;
      eop_block <= 1'b0;
    end else begin
      state <= state_next;
      DREQ  <= (state_next == REQ) || (state_next == XFER);
      ior_q <= IOR_N;
      iow_q <= IOW_N;
      if (eop_in)     eop_block <= 1'b1;
      else if (!DACK) eop_block <= 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      tx_wr  <= 2'd0;
      tx_rd  <= 2'd0;
      tx_cnt <= 3'd0;
      rx_wr  <= 2'd0;
      rx_rd  <= 2'd0;
      rx_cnt <= 3'd0;
    end else begin
      if (tx_push) tx_wr <= tx_wr + 2'd1;
      if (tx_pop)  tx_rd <= tx_rd + 2'd1;
      tx_cnt <= tx_cnt_next;
      if (rx_push) rx_wr <= rx_wr + 2'd1;
      if (rx_pop)  rx_rd <= rx_rd + 2'd1;
      rx_cnt <= rx_cnt_next;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET && tx_push) tx_mem[tx_wr] <= txData;
    if (!RESET && rx_push) rx_mem[rx_wr] <= DB;
  end

endmodule

// File: tb/tb_dma_io_device.sv
// Directed bench for dma_io_device: reset, single/demand transfers, EOP abort, full FIFO push+pop,
// and terminal count when DMA_DEV_TERMINAL_COUNT_EN is defined.
module tb_dma_io_device;

  logic       CLK = 1'b0;
  logic       RESET, DACK, IOR_N, IOW_N, EOP_N;
  logic [7:0] DB, txData, blockLen;
  logic       enable, dir, demandMode, txPush, rxPop;
  logic       DREQ, DB_OE, EOP_OUT_N, txFull, rxEmpty;
  logic [7:0] DB_OUT, rxData;
  logic [1:0] dbg_state;

  int tests_run = 0;
  int tests_failed = 0;
  logic [7:0] exp_q[$];

  dma_io_device dut (
    .CLK(CLK), .RESET(RESET), .DREQ(DREQ), .DACK(DACK), .IOR_N(IOR_N), .IOW_N(IOW_N),
    .EOP_N(EOP_N), .DB(DB), .DB_OUT(DB_OUT), .DB_OE(DB_OE), .EOP_OUT_N(EOP_OUT_N),
    .enable(enable), .dir(dir), .demandMode(demandMode), .txPush(txPush), .txData(txData),
    .txFull(txFull), .rxPop(rxPop), .rxData(rxData), .rxEmpty(rxEmpty), .blockLen(blockLen),
    .dbg_state(dbg_state)
  );

  // Clock and reset
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks: inputs change 1 time unit after posedge, outputs are read there too.
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
  endtask

  task automatic push_tx(input logic [7:0] b);
    txPush = 1'b1;
    txData = b;
    tick();
    txPush = 1'b0;
  endtask

  task automatic wait_dreq(input logic level, output logic ok);
    int i;
    i = 0;
    while (DREQ !== level && i < 20) begin
      tick();
      i++;
    end
    ok = (DREQ === level);
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 4; i++) push_tx(8'(i + 1));
    tests_run++; if (txFull !== 1'b1) begin tests_failed++; $display("FAIL pre_reset_full got=%b exp=1", txFull); end
    txPush = 1'b1; txData = 8'h55; RESET = 1'b1;
    tick();
    tests_run++; if (DREQ !== 1'b0) begin tests_failed++; $display("FAIL reset_dreq got=%b exp=0", DREQ); end
    tests_run++; if (txFull !== 1'b0) begin tests_failed++; $display("FAIL reset_txfull got=%b exp=0", txFull); end
    tests_run++; if (rxEmpty !== 1'b1) begin tests_failed++; $display("FAIL reset_rxempty got=%b exp=1", rxEmpty); end
    tests_run++; if (EOP_OUT_N !== 1'b1) begin tests_failed++; $display("FAIL reset_eop_out got=%b exp=1", EOP_OUT_N); end
    tests_run++; if (DB_OE !== 1'b0 || DB_OUT !== 8'h00) begin tests_failed++; $display("FAIL reset_db got oe=%b out=%h exp oe=0 out=00", DB_OE, DB_OUT); end
    tests_run++; if (dbg_state !== 2'd0) begin tests_failed++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
    txPush = 1'b0; RESET = 1'b0;
    tick();
  endtask

  task automatic test_single_read();
    do_reset();
    dir = 1'b1; demandMode = 1'b0;
    push_tx(8'hA5);
    push_tx(8'h3C);
    enable = 1'b1;
    tick();
    tests_run++; if (DREQ !== 1'b1 || dbg_state !== 2'd1) begin tests_failed++; $display("FAIL single_req got dreq=%b st=%0d exp dreq=1 st=1", DREQ, dbg_state); end
    DACK = 1'b1;
    tick();
    tests_run++; if (dbg_state !== 2'd2) begin tests_failed++; $display("FAIL single_xfer got st=%0d exp=2", dbg_state); end
    // wrong-direction strobe must be ignored
    IOW_N = 1'b0; #1;
    tests_run++; if (DB_OE !== 1'b0) begin tests_failed++; $display("FAIL wrongdir_oe got=%b exp=0", DB_OE); end
    tick();
    tests_run++; if (rxEmpty !== 1'b1 || dbg_state !== 2'd2) begin tests_failed++; $display("FAIL wrongdir_push got rxempty=%b st=%0d exp rxempty=1 st=2", rxEmpty, dbg_state); end
    IOW_N = 1'b1;
    tick();
    IOR_N = 1'b0; #1;
    tests_run++; if (DB_OE !== 1'b1 || DB_OUT !== 8'hA5) begin tests_failed++; $display("FAIL single_byte0 got oe=%b out=%h exp oe=1 out=a5", DB_OE, DB_OUT); end
    tick();
    tests_run++; if (DREQ !== 1'b0 || dbg_state !== 2'd3) begin tests_failed++; $display("FAIL single_gap got dreq=%b st=%0d exp dreq=0 st=3", DREQ, dbg_state); end
    IOR_N = 1'b1;
    tick();
    tests_run++; if (DREQ !== 1'b1) begin tests_failed++; $display("FAIL single_gap_len got dreq=%b exp=1", DREQ); end
    tick();
    IOR_N = 1'b0; #1;
    tests_run++; if (DB_OUT !== 8'h3C) begin tests_failed++; $display("FAIL single_byte1 got=%h exp=3c", DB_OUT); end
    tick();
    IOR_N = 1'b1;
    tick();
    tests_run++; if (DREQ !== 1'b0 || dbg_state !== 2'd0) begin tests_failed++; $display("FAIL single_done got dreq=%b st=%0d exp dreq=0 st=0", DREQ, dbg_state); end
    DACK = 1'b0; enable = 1'b0;
    tick();
  endtask

  task automatic test_demand_write();
    do_reset();
    dir = 1'b0; demandMode = 1'b1; enable = 1'b1;
    tick();
    tests_run++; if (DREQ !== 1'b1) begin tests_failed++; $display("FAIL demand_req got=%b exp=1", DREQ); end
    DACK = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      DB = 8'((k + 1) * 17);
      IOW_N = 1'b0;
      tick();
      if (k < 3) begin
        tests_run++; if (DREQ !== 1'b1) begin tests_failed++; $display("FAIL demand_hold%0d got=%b exp=1", k, DREQ); end
      end else begin
        tests_run++; if (DREQ !== 1'b0 || dbg_state !== 2'd0) begin tests_failed++; $display("FAIL demand_full got dreq=%b st=%0d exp dreq=0 st=0", DREQ, dbg_state); end
      end
      IOW_N = 1'b1;
      tick();
    end
    tests_run++; if (rxEmpty !== 1'b0 || rxData !== 8'h11) begin tests_failed++; $display("FAIL demand_head got empty=%b data=%h exp empty=0 data=11", rxEmpty, rxData); end
    enable = 1'b0; DACK = 1'b0;
    rxPop = 1'b1;
    tick();
    rxPop = 1'b0;
    tests_run++; if (rxData !== 8'h22) begin tests_failed++; $display("FAIL demand_pop got=%h exp=22", rxData); end
    tests_run++; if (EOP_OUT_N !== 1'b1) begin tests_failed++; $display("FAIL demand_eop_out got=%b exp=1", EOP_OUT_N); end
  endtask

  task automatic test_eop_abort();
    logic ok;
    do_reset();
    dir = 1'b1; demandMode = 1'b1;
    push_tx(8'h61); push_tx(8'h62); push_tx(8'h63);
    enable = 1'b1;
    tick();
    DACK = 1'b1;
    tick();
    IOR_N = 1'b0;
    tick();
    IOR_N = 1'b1;
    tick();
    tests_run++; if (DREQ !== 1'b1) begin tests_failed++; $display("FAIL eop_pre got=%b exp=1", DREQ); end
    EOP_N = 1'b0;
    tick();
    tests_run++; if (DREQ !== 1'b0 || dbg_state !== 2'd0) begin tests_failed++; $display("FAIL eop_drop got dreq=%b st=%0d exp dreq=0 st=0", DREQ, dbg_state); end
    EOP_N = 1'b1; IOR_N = 1'b0;
    tick();
    tests_run++; if (DREQ !== 1'b0 || DB_OUT !== 8'h62) begin tests_failed++; $display("FAIL eop_blocked got dreq=%b out=%h exp dreq=0 out=62", DREQ, DB_OUT); end
    IOR_N = 1'b1;
    tick(2);
    tests_run++; if (DREQ !== 1'b0) begin tests_failed++; $display("FAIL eop_hold got=%b exp=0", DREQ); end
    DACK = 1'b0;
    tick();
    wait_dreq(1'b1, ok);
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL eop_rerequest got dreq=%b exp=1 within 20 cycles", DREQ); end
    DACK = 1'b1;
    tick();
    IOR_N = 1'b0; #1;
    tests_run++; if (DB_OUT !== 8'h62) begin tests_failed++; $display("FAIL eop_rem0 got=%h exp=62", DB_OUT); end
    tick();
    IOR_N = 1'b1;
    tick();
    IOR_N = 1'b0; #1;
    tests_run++; if (DB_OUT !== 8'h63) begin tests_failed++; $display("FAIL eop_rem1 got=%h exp=63", DB_OUT); end
    tick();
    tests_run++; if (DREQ !== 1'b0) begin tests_failed++; $display("FAIL eop_drain got=%b exp=0", DREQ); end
    IOR_N = 1'b1; enable = 1'b0; DACK = 1'b0;
    tick();
  endtask

  task automatic test_full_push_pop();
    logic [7:0] exp_b;
    do_reset();
    exp_q.delete();
    dir = 1'b1; demandMode = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      push_tx(8'(i));
      exp_q.push_back(8'(i));
    end
    tests_run++; if (txFull !== 1'b1) begin tests_failed++; $display("FAIL full_flag got=%b exp=1", txFull); end
    push_tx(8'h99);
    enable = 1'b1;
    tick();
    DACK = 1'b1;
    tick();
    txPush = 1'b1; txData = 8'h05; IOR_N = 1'b0; #1;
    exp_b = exp_q.pop_front();
    tests_run++; if (DB_OUT !== exp_b) begin tests_failed++; $display("FAIL full_head got=%h exp=%h", DB_OUT, exp_b); end
    exp_q.push_back(8'h05);
    tick();
    txPush = 1'b0;
    tests_run++; if (txFull !== 1'b1) begin tests_failed++; $display("FAIL full_pushpop got=%b exp=1", txFull); end
    IOR_N = 1'b1;
    tick();
    while (exp_q.size() > 0) begin
      exp_b = exp_q.pop_front();
      IOR_N = 1'b0; #1;
      tests_run++; if (DB_OUT !== exp_b) begin tests_failed++; $display("FAIL full_drain got=%h exp=%h", DB_OUT, exp_b); end
      tick();
      IOR_N = 1'b1;
      tick();
    end
    tests_run++; if (DREQ !== 1'b0 || txFull !== 1'b0) begin tests_failed++; $display("FAIL full_end got dreq=%b full=%b exp dreq=0 full=0", DREQ, txFull); end
    enable = 1'b0; DACK = 1'b0;
    tick();
  endtask

`ifdef DMA_DEV_TERMINAL_COUNT_EN
  task automatic test_terminal_count();
    do_reset();
    blockLen = 8'd2; dir = 1'b1; demandMode = 1'b1;
    push_tx(8'h71); push_tx(8'h72); push_tx(8'h73);
    enable = 1'b1;
    tick();
    DACK = 1'b1;
    tick();
    IOR_N = 1'b0;
    tick();
    tests_run++; if (EOP_OUT_N !== 1'b1 || DREQ !== 1'b1) begin tests_failed++; $display("FAIL tc_first got eop=%b dreq=%b exp eop=1 dreq=1", EOP_OUT_N, DREQ); end
    IOR_N = 1'b1;
    tick();
    IOR_N = 1'b0;
    tick();
    tests_run++; if (EOP_OUT_N !== 1'b0 || DREQ !== 1'b0 || dbg_state !== 2'd0) begin tests_failed++; $display("FAIL tc_hit got eop=%b dreq=%b st=%0d exp eop=0 dreq=0 st=0", EOP_OUT_N, DREQ, dbg_state); end
    IOR_N = 1'b1; enable = 1'b0;
    tick();
    tests_run++; if (EOP_OUT_N !== 1'b1) begin tests_failed++; $display("FAIL tc_pulse got=%b exp=1", EOP_OUT_N); end
    IOR_N = 1'b0; #1;
    tests_run++; if (DB_OUT !== 8'h73) begin tests_failed++; $display("FAIL tc_left got=%h exp=73", DB_OUT); end
    IOR_N = 1'b1; DACK = 1'b0; blockLen = 8'd0;
    tick();
  endtask
`else
  task automatic test_terminal_count();
    do_reset();
    blockLen = 8'd1; dir = 1'b1; demandMode = 1'b1;
    push_tx(8'h71); push_tx(8'h72);
    enable = 1'b1;
    tick();
    DACK = 1'b1;
    tick();
    IOR_N = 1'b0;
    tick();
    tests_run++; if (EOP_OUT_N !== 1'b1 || DREQ !== 1'b1) begin tests_failed++; $display("FAIL no_tc got eop=%b dreq=%b exp eop=1 dreq=1", EOP_OUT_N, DREQ); end
    IOR_N = 1'b1; enable = 1'b0; DACK = 1'b0; blockLen = 8'd0;
    tick(2);
  endtask
`endif

  initial begin
    RESET = 1'b1; DACK = 1'b0; IOR_N = 1'b1; IOW_N = 1'b1; EOP_N = 1'b1;
    DB = 8'h00; txData = 8'h00; blockLen = 8'd0;
    enable = 1'b0; dir = 1'b0; demandMode = 1'b0; txPush = 1'b0; rxPop = 1'b0;
    test_reset();
    test_single_read();
    test_demand_write();
    test_eop_abort();
    test_full_push_pop();
    test_terminal_count();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
